// File: rtl/router_pkg.sv
// router_pkg
// Shared types and constants for the round-robin output router.
//   DATA_W_DFLT / DEST_W_DFLT : default beat and destination-field widths
//   fsm_state_t               : arbiter FSM states
//   beat_ctl_t                : per-beat qualifiers stored with each buffered beat
//   buf_entry_t               : full buffer entry at the default data width
//   next_idx()                : wrapping increment for port indices
package router_pkg;

   localparam int DATA_W_DFLT = 64;
   localparam int DEST_W_DFLT = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } fsm_state_t;

   typedef struct packed {
      logic hdr_v;
      logic pld_v;
      logic sof;
      logic eof;
   } beat_ctl_t;

   localparam int CTL_W = $bits(beat_ctl_t);

   // Buffer entry layout at the default width. Non-default widths use the
   // same ordering: data in the upper bits, qualifiers in the low CTL_W bits.
   typedef struct packed {
      logic [DATA_W_DFLT-1:0] data;
      logic                   hdr_v;
      logic                   pld_v;
      logic                   sof;
      logic                   eof;
   } buf_entry_t;

   function automatic int next_idx(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/router_skid_fifo.sv
// router_skid_fifo
// Small output buffer between the arbiter and the downstream sink.
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write one entry (dropped when full and not popping)
//   pop        : remove the head entry if one is present
//   dout       : head entry, all zeros when empty
//   level_nxt  : occupancy after this cycle's push/pop
//   overflow   : pulses when a push is dropped
module router_skid_fifo #(
   parameter int Width = 8,
   parameter int Depth = 2,
   parameter int CntW  = $clog2(Depth + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [Width-1:0] din,
   input  logic             pop,
   output logic [Width-1:0] dout,
   output logic [CntW-1:0]  level_nxt,
   output logic             overflow
);

   localparam int AddrW = (Depth > 1) ? $clog2(Depth) : 1;

   logic [Width-1:0] mem [Depth];
   logic [AddrW-1:0] wr_ptr;
   logic [AddrW-1:0] rd_ptr;
   logic [CntW-1:0]  level;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AddrW-1:0] bump(input logic [AddrW-1:0] p);
      return (p == AddrW'(Depth - 1)) ? '0 : p + AddrW'(1);
   endfunction

   assign empty     = (level == '0);
   assign full      = (level == CntW'(Depth));
   assign do_pop    = pop & ~empty;
   // A full buffer still takes a beat when the head leaves in the same cycle.
   assign do_push   = push & (~full | do_pop);
   assign overflow  = push & ~do_push;
   assign level_nxt = level + CntW'(do_push) - CntW'(do_pop);
   assign dout      = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= bump(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= bump(rd_ptr);
         end
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/router_muxn_rr.sv
// router_muxn_rr
// One router output: picks among NumPorts sources whose SOF targets PortNo,
// round-robin, and forwards the whole packet of the granted source through
// a skid buffer.
//   CLK, RST                     : clock, asynchronous active-high reset
//   D, DEST                      : per-port beat data and destination field
//   DEST_VALID, D_HDR_VALID,
//   D_PLD_VALID, D_SOF, D_EOF    : per-port qualifiers
//   D_BP                         : registered backpressure, granted port only
//   Q, Q_HDR_VALID, Q_PLD_VALID,
//   Q_SOF, Q_EOF                 : buffer head, zero when empty
//   Q_BP                         : downstream backpressure
//   ERR_OVF                      : sticky buffer-overflow flag
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no packet open; a request here is granted and its beat taken
// ST_BUSY | packet open on gnt; valid beats from gnt taken until EOF
module router_muxn_rr
   import router_pkg::*;
#(
   parameter int NumPorts  = 4,
   parameter int PortNo    = 1,
   parameter int DataWidth = DATA_W_DFLT,
   parameter int DestWidth = DEST_W_DFLT,
   parameter int SkidDepth = 2
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NumPorts*DataWidth-1:0] D,
   input  logic [NumPorts*DestWidth-1:0] DEST,
   input  logic [NumPorts-1:0]           DEST_VALID,
   input  logic [NumPorts-1:0]           D_HDR_VALID,
   input  logic [NumPorts-1:0]           D_PLD_VALID,
   input  logic [NumPorts-1:0]           D_SOF,
   input  logic [NumPorts-1:0]           D_EOF,
   output logic [NumPorts-1:0]           D_BP,
   output logic [DataWidth-1:0]          Q,
   output logic                          Q_HDR_VALID,
   output logic                          Q_PLD_VALID,
   output logic                          Q_SOF,
   output logic                          Q_EOF,
   input  logic                          Q_BP,
   output logic                          ERR_OVF
);

   localparam int IdxW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
   localparam int EntW = DataWidth + CTL_W;
   localparam int CntW = $clog2(SkidDepth + 1);

   fsm_state_t           state;
   fsm_state_t           state_nxt;
   logic [IdxW-1:0]      ptr;
   logic [IdxW-1:0]      ptr_nxt;
   logic [IdxW-1:0]      gnt;
   logic [IdxW-1:0]      gnt_nxt;
   logic [IdxW-1:0]      cur;
   logic [IdxW-1:0]      arb_idx;
   logic                 arb_hit;
   logic [NumPorts-1:0]  req;
   logic [NumPorts-1:0]  bp_nxt;
   logic                 push;
   logic                 push_sof;
   logic                 bp_valid;
   beat_ctl_t            push_ctl;
   beat_ctl_t            head_ctl;
   logic [DataWidth-1:0] push_data;
   logic [EntW-1:0]      fifo_din;
   logic [EntW-1:0]      fifo_dout;
   logic [CntW-1:0]      level_nxt;
   logic                 fifo_ovf;

   always_comb begin
      req = '0;
      for (int i = 0; i < NumPorts; i++) begin
         req[i] = D_SOF[i] & DEST_VALID[i]
                & (DEST[i*DestWidth +: DestWidth] == DestWidth'(PortNo));
      end
   end

   // First requester at or after ptr, wrapping.
   always_comb begin : arb
      int idx;
      arb_hit = 1'b0;
      arb_idx = '0;
      idx     = 0;
      for (int k = 0; k < NumPorts; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NumPorts) begin
            idx = idx - NumPorts;
         end
         if (!arb_hit && req[idx]) begin
            arb_hit = 1'b1;
            arb_idx = IdxW'(idx);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gnt_nxt   = gnt;
      cur       = gnt;
      push      = 1'b0;
      push_sof  = 1'b0;
      bp_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arb_hit) begin
               cur      = arb_idx;
               push     = 1'b1;
               push_sof = 1'b1;
               bp_valid = 1'b1;
               gnt_nxt  = arb_idx;
               ptr_nxt  = IdxW'(next_idx(int'(arb_idx), NumPorts));
               if (!D_EOF[arb_idx]) begin
                  state_nxt = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            bp_valid = 1'b1;
            if (D_HDR_VALID[gnt] | D_PLD_VALID[gnt]) begin
               push = 1'b1;
               // EOF closes the packet even if the buffer drops the beat,
               // so an overflow cannot wedge the FSM in BUSY.
               if (D_EOF[gnt]) begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      push_data      = D[int'(cur)*DataWidth +: DataWidth];
      push_ctl.hdr_v = D_HDR_VALID[cur];
      push_ctl.pld_v = D_PLD_VALID[cur];
      push_ctl.sof   = push_sof;
      push_ctl.eof   = D_EOF[cur];
   end

   // Backpressure follows the occupancy this cycle leaves behind, so it
   // reaches the source one cycle later from a flop.
   always_comb begin
      bp_nxt = '0;
      if (bp_valid && (level_nxt >= CntW'(SkidDepth - 1))) begin
         bp_nxt[cur] = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= ST_IDLE;
         ptr     <= '0;
         gnt     <= '0;
         D_BP    <= '0;
         ERR_OVF <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         gnt   <= gnt_nxt;
         D_BP  <= bp_nxt;
         if (fifo_ovf) begin
            ERR_OVF <= 1'b1;
         end
      end
   end

   assign fifo_din = {push_data, push_ctl};

   router_skid_fifo #(
      .Width (EntW),
      .Depth (SkidDepth),
      .CntW  (CntW)
   ) u_skid (
      .clk       (CLK),
      .rst       (RST),
      .push      (push),
      .din       (fifo_din),
      .pop       (~Q_BP),
      .dout      (fifo_dout),
      .level_nxt (level_nxt),
      .overflow  (fifo_ovf)
   );

   assign {Q, head_ctl} = fifo_dout;
   assign Q_HDR_VALID   = head_ctl.hdr_v;
   assign Q_PLD_VALID   = head_ctl.pld_v;
   assign Q_SOF         = head_ctl.sof;
   assign Q_EOF         = head_ctl.eof;

endmodule
